// File: rtl/usr_pkg.sv
// Shared mode encodings for the universal shift register.
package usr_pkg;

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_LOAD  = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_SHR   = 3'b011;
    localparam logic [2:0] MODE_ROL   = 3'b100;
    localparam logic [2:0] MODE_ROR   = 3'b101;
    localparam logic [2:0] MODE_ASR   = 3'b110;
    localparam logic [2:0] MODE_CLEAR = 3'b111;

endpackage

// File: rtl/d_ff_cell.sv
// One-bit rising-edge D flip-flop with synchronous reset to a per-cell value.
module d_ff_cell (
    input  logic clock,
    input  logic reset,
    input  logic rst_val,
    input  logic D,
    output logic Q,
    output logic NQ
);

    logic q_r;

    // Storage bit: reset wins over data.
    always_ff @(posedge clock) begin
        if (reset) begin
            q_r <= rst_val;
        end else begin
            q_r <= D;
        end
    end

    assign Q  = q_r;
    assign NQ = ~q_r;

endmodule

// File: rtl/universal_shift_register.sv
// WIDTH-bit multi-mode register: load, shifts, rotates, arithmetic right shift
// and a flag holding the bit that most recently left the register.
module universal_shift_register
    import usr_pkg::*;
#(
    parameter int                 WIDTH       = 8,
    parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] D,
    input  logic             sl_in,
    input  logic             sr_in,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] NQ,
    output logic             shift_out
);

    logic [WIDTH-1:0] q_s;
    logic [WIDTH-1:0] nq_s;
    logic [WIDTH-1:0] next_s;
    logic             so_q_s;
    logic             so_next_s;

    // Each extended vector carries the shifted result plus the departing bit at
    // the far end, so WIDTH = 1 needs no special case.
    logic [WIDTH:0] shl_ext_s;
    logic [WIDTH:0] shr_ext_s;
    logic [WIDTH:0] rol_ext_s;
    logic [WIDTH:0] ror_ext_s;
    logic [WIDTH:0] asr_ext_s;

    assign shl_ext_s = {q_s, sl_in};
    assign shr_ext_s = {sr_in, q_s};
    assign rol_ext_s = {q_s, q_s[WIDTH-1]};
    assign ror_ext_s = {q_s[0], q_s};
    assign asr_ext_s = {q_s[WIDTH-1], q_s};

    // Next-state and departing-bit selection by mode.
    always_comb begin
        next_s    = q_s;
        so_next_s = so_q_s;
        case (mode)
            MODE_HOLD: begin
                next_s    = q_s;
                so_next_s = so_q_s;
            end
            MODE_LOAD: begin
                next_s    = D;
                so_next_s = so_q_s;
            end
            MODE_SHL: begin
                next_s    = shl_ext_s[WIDTH-1:0];
                so_next_s = shl_ext_s[WIDTH];
            end
            MODE_SHR: begin
                next_s    = shr_ext_s[WIDTH:1];
                so_next_s = shr_ext_s[0];
            end
            MODE_ROL: begin
                next_s    = rol_ext_s[WIDTH-1:0];
                so_next_s = rol_ext_s[WIDTH];
            end
            MODE_ROR: begin
                next_s    = ror_ext_s[WIDTH:1];
                so_next_s = ror_ext_s[0];
            end
            MODE_ASR: begin
                next_s    = asr_ext_s[WIDTH:1];
                so_next_s = asr_ext_s[0];
            end
            MODE_CLEAR: begin
                next_s    = {WIDTH{1'b0}};
                so_next_s = 1'b0;
            end
            default: begin
                next_s    = q_s;
                so_next_s = so_q_s;
            end
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        d_ff_cell u_cell (
            .clock   (clock),
            .reset   (reset),
            .rst_val (RESET_VALUE[i]),
            .D       (next_s[i]),
            .Q       (q_s[i]),
            .NQ      (nq_s[i])
        );
    end

    d_ff_cell u_shift_out (
        .clock   (clock),
        .reset   (reset),
        .rst_val (1'b0),
        .D       (so_next_s),
        .Q       (so_q_s),
        .NQ      ()
    );

    assign Q         = q_s;
    assign NQ        = nq_s;
    assign shift_out = so_q_s;

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed bench for universal_shift_register: three instances (default, non-zero
// reset value, one bit wide) checked every cycle against an arithmetic model.
module tb_universal_shift_register;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] mode  = 3'b001;
    logic [7:0] d_in  = 8'hFF;
    logic       sl_in = 1'b0;
    logic       sr_in = 1'b0;

    logic [7:0] q8, nq8, qr, nqr;
    logic       so8, sor;
    logic [0:0] q1, nq1;
    logic       so1;

    int checks = 0;
    int errors = 0;

    logic [7:0] m8, mr;
    logic       ms8, msr;
    logic [7:0] m1;
    logic       ms1;
    logic       mvalid = 1'b0;

    always #5 clock = ~clock;

    universal_shift_register #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .mode(mode), .D(d_in), .sl_in(sl_in),
        .sr_in(sr_in), .Q(q8), .NQ(nq8), .shift_out(so8)
    );

    universal_shift_register #(.WIDTH(8), .RESET_VALUE(8'h3C)) dut_rv (
        .clock(clock), .reset(reset), .mode(mode), .D(d_in), .sl_in(sl_in),
        .sr_in(sr_in), .Q(qr), .NQ(nqr), .shift_out(sor)
    );

    universal_shift_register #(.WIDTH(1)) dut1 (
        .clock(clock), .reset(reset), .mode(mode), .D(d_in[0:0]), .sl_in(sl_in),
        .sr_in(sr_in), .Q(q1), .NQ(nq1), .shift_out(so1)
    );

    // Model: register value as an integer, operations as plain shifts and masks.
    function automatic logic [8:0] model_next(input int w, input logic [7:0] q,
                                              input logic [2:0] md, input logic [7:0] d,
                                              input logic sl, input logic sr, input logic so);
        int mask, qi, top, lsb, nq, nso;
        mask = (1 << w) - 1;
        qi   = int'(q) & mask;
        top  = (qi >> (w - 1)) & 1;
        lsb  = qi & 1;
        nq   = qi;
        nso  = int'(so);
        case (md)
            3'd0: nq = qi;
            3'd1: nq = int'(d) & mask;
            3'd2: begin nq = ((qi << 1) | int'(sl)) & mask;  nso = top; end
            3'd3: begin nq = (qi >> 1) | (int'(sr) << (w - 1)); nso = lsb; end
            3'd4: begin nq = ((qi << 1) | top) & mask;       nso = top; end
            3'd5: begin nq = (qi >> 1) | (lsb << (w - 1));   nso = lsb; end
            3'd6: begin nq = (qi >> 1) | (top << (w - 1));   nso = lsb; end
            default: begin nq = 0; nso = 0; end
        endcase
        return {nso[0], nq[7:0]};
    endfunction

    // Model state update on each rising edge.
    always @(posedge clock) begin
        if (reset) begin
            m8 <= 8'h00; ms8 <= 1'b0;
            mr <= 8'h3C; msr <= 1'b0;
            m1 <= 8'h00; ms1 <= 1'b0;
            mvalid <= 1'b1;
        end else if (mvalid) begin
            {ms8, m8} <= model_next(8, m8, mode, d_in, sl_in, sr_in, ms8);
            {msr, mr} <= model_next(8, mr, mode, d_in, sl_in, sr_in, msr);
            {ms1, m1} <= model_next(1, m1, mode, d_in, sl_in, sr_in, ms1);
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (mvalid) begin
            chk("q8",   q8,  m8);
            chk("nq8",  nq8, ~m8);
            chk("so8",  {7'd0, so8}, {7'd0, ms8});
            chk("qrv",  qr,  mr);
            chk("nqrv", nqr, ~mr);
            chk("sorv", {7'd0, sor}, {7'd0, msr});
            chk("q1",   {7'd0, q1},  m1);
            chk("nq1",  {7'd0, nq1}, {7'd0, ~m1[0]});
            chk("so1",  {7'd0, so1}, {7'd0, ms1});
        end
    end

    task automatic step(input logic [2:0] md, input logic [7:0] d, input logic sl,
                        input logic sr, input logic rst);
        mode  = md;
        d_in  = d;
        sl_in = sl;
        sr_in = sr;
        reset = rst;
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset while LOAD of all-ones is requested.
        step(3'b001, 8'hFF, 1'b0, 1'b0, 1'b1);
        chk("rst_q",    q8,  8'h00);
        chk("rst_nq",   nq8, 8'hFF);
        chk("rst_so",   {7'd0, so8}, 8'h00);
        chk("rst_rv_q", qr,  8'h3C);
        chk("rst_rv_nq", nqr, 8'hC3);

        // Load then hold.
        step(3'b001, 8'hA5, 1'b0, 1'b0, 1'b0);
        chk("load_q",  q8,  8'hA5);
        chk("load_nq", nq8, 8'h5A);
        for (int i = 0; i < 3; i++) begin
            step(3'b000, 8'h00, 1'b1, 1'b1, 1'b0);
            chk("hold_q", q8, 8'hA5);
        end

        // Shifts from A5.
        step(3'b010, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("shl_q",  q8, 8'h4B);
        chk("shl_so", {7'd0, so8}, 8'h01);
        step(3'b011, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("shr_q",  q8, 8'h25);
        chk("shr_so", {7'd0, so8}, 8'h01);

        // Rotates, arithmetic shift, clear.
        step(3'b001, 8'h81, 1'b0, 1'b0, 1'b0);
        step(3'b100, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("rol_q",  q8, 8'h03);
        chk("rol_so", {7'd0, so8}, 8'h01);
        step(3'b101, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("ror_q",  q8, 8'h81);
        chk("ror_so", {7'd0, so8}, 8'h01);
        step(3'b001, 8'h80, 1'b0, 1'b0, 1'b0);
        step(3'b110, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("asr1_q",  q8, 8'hC0);
        chk("asr1_so", {7'd0, so8}, 8'h00);
        step(3'b110, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("asr2_q",  q8, 8'hE0);
        step(3'b111, 8'hFF, 1'b1, 1'b1, 1'b0);
        chk("clr_q",  q8, 8'h00);
        chk("clr_so", {7'd0, so8}, 8'h00);

        // Reset in the middle of a shift sequence.
        step(3'b001, 8'hF0, 1'b0, 1'b0, 1'b0);
        step(3'b010, 8'h00, 1'b0, 1'b0, 1'b0);
        step(3'b010, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("mid_shl_q", q8, 8'hC0);
        step(3'b010, 8'h00, 1'b1, 1'b0, 1'b1);
        chk("mid_rst_q",  q8, 8'h00);
        chk("mid_rst_so", {7'd0, so8}, 8'h00);
        chk("mid_rst_rv", qr, 8'h3C);
        step(3'b010, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("post_rst_q",  q8, 8'h01);
        chk("post_rst_so", {7'd0, so8}, 8'h00);

        // One-bit instance.
        step(3'b001, 8'h00, 1'b0, 1'b0, 1'b0);
        step(3'b010, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("w1_shl_q",  {7'd0, q1},  8'h01);
        chk("w1_shl_nq", {7'd0, nq1}, 8'h00);
        step(3'b100, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("w1_rol_q",  {7'd0, q1},  8'h01);
        chk("w1_rol_so", {7'd0, so1}, 8'h01);
        step(3'b011, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("w1_shr_q",  {7'd0, q1},  8'h00);
        chk("w1_shr_so", {7'd0, so1}, 8'h01);
        chk("w1_shr_nq", {7'd0, nq1}, 8'h01);

        // Back-to-back mode changes every cycle, model-checked.
        for (int i = 0; i < 48; i++) begin
            logic [7:0] pat;
            logic [2:0] md;
            pat = 8'h5A ^ 8'(i * 37);
            md  = 3'((i * 5) % 8);
            step(md, pat, pat[0], pat[3], (i == 30));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
